// File: rtl/mon_tcam_arbiter.sv
// mon_tcam_arbiter: round-robin host/engine arbiter for single-port TCAM rule access with ack timeout.
module mon_tcam_arbiter #(
  parameter int TUPLE_WIDTH = 104,
  parameter int MON_LUT_DEPTH_BITS = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          axi_aclk,
  input  logic                          axi_resetn,
  input  logic                          h_req,
  input  logic                          h_wr,
  input  logic [MON_LUT_DEPTH_BITS-1:0] h_addr,
  input  logic [TUPLE_WIDTH-1:0]        h_rule,
  input  logic [TUPLE_WIDTH-1:0]        h_mask,
  output logic                          h_ack,
  output logic                          h_err,
  output logic [TUPLE_WIDTH-1:0]        h_rd_rule,
  output logic [TUPLE_WIDTH-1:0]        h_rd_mask,
  input  logic                          e_req,
  input  logic                          e_wr,
  input  logic [MON_LUT_DEPTH_BITS-1:0] e_addr,
  input  logic [TUPLE_WIDTH-1:0]        e_rule,
  input  logic [TUPLE_WIDTH-1:0]        e_mask,
  output logic                          e_ack,
  output logic                          e_err,
  output logic [TUPLE_WIDTH-1:0]        e_rd_rule,
  output logic [TUPLE_WIDTH-1:0]        e_rd_mask,
  output logic                          mon_rd_req,
  output logic                          mon_wr_req,
  output logic [MON_LUT_DEPTH_BITS-1:0] mon_rd_addr,
  output logic [MON_LUT_DEPTH_BITS-1:0] mon_wr_addr,
  output logic [TUPLE_WIDTH-1:0]        mon_wr_rule,
  output logic [TUPLE_WIDTH-1:0]        mon_wr_rulemask,
  input  logic [TUPLE_WIDTH-1:0]        mon_rd_rule,
  input  logic [TUPLE_WIDTH-1:0]        mon_rd_rulemask,
  input  logic                          mon_rd_ack,
  input  logic                          mon_wr_ack,
  output logic                          busy
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DONE} state_t;
  state_t state;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic last_e, block, sel_e, wr;
  logic [MON_LUT_DEPTH_BITS-1:0] addr;
  logic [TUPLE_WIDTH-1:0] rule, mask;
  logic h_ok, e_ok, pick_e, pick_wr, matched;
  // the requester just served is masked for one IDLE cycle so a held req cannot double-grant
  assign h_ok = h_req && !(block && !last_e);
  assign e_ok = e_req && !(block && last_e);
  assign pick_e = e_ok && (!h_ok || !last_e);
  assign pick_wr = pick_e ? e_wr : h_wr;
  assign matched = wr ? mon_wr_ack : mon_rd_ack;
  assign busy = state != IDLE;
  assign mon_rd_addr = addr;
  assign mon_wr_addr = addr;
  assign mon_wr_rule = rule;
  assign mon_wr_rulemask = mask;
  always_ff @(posedge axi_aclk or negedge axi_resetn)
    if (!axi_resetn) sync <= '0;
    else sync <= {sync[0], 1'b1};
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state <= IDLE;
      cnt <= '0;
      last_e <= 1'b1;
      block <= 1'b0;
      sel_e <= 1'b0;
      wr <= 1'b0;
      addr <= '0;
      rule <= '0;
      mask <= '0;
      mon_rd_req <= 1'b0;
      mon_wr_req <= 1'b0;
      h_ack <= 1'b0;
      h_err <= 1'b0;
      e_ack <= 1'b0;
      e_err <= 1'b0;
      h_rd_rule <= '0;
      h_rd_mask <= '0;
      e_rd_rule <= '0;
      e_rd_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          block <= 1'b0;
          if (sync[1] && (h_ok || e_ok)) begin
            state <= ISSUE;
            sel_e <= pick_e;
            last_e <= pick_e;
            wr <= pick_wr;
            addr <= pick_e ? e_addr : h_addr;
            rule <= pick_e ? e_rule : h_rule;
            mask <= pick_e ? e_mask : h_mask;
            mon_wr_req <= pick_wr;
            mon_rd_req <= !pick_wr;
          end
        end
        ISSUE: begin
          mon_wr_req <= 1'b0;
          mon_rd_req <= 1'b0;
          cnt <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (matched || cnt == TERM) begin
            state <= DONE;
            h_ack <= !sel_e;
            e_ack <= sel_e;
            h_err <= !sel_e && !matched;
            e_err <= sel_e && !matched;
            if (matched && !wr && sel_e) begin
              e_rd_rule <= mon_rd_rule;
              e_rd_mask <= mon_rd_rulemask;
            end
            if (matched && !wr && !sel_e) begin
              h_rd_rule <= mon_rd_rule;
              h_rd_mask <= mon_rd_rulemask;
            end
          end else cnt <= cnt + 1'b1;
        end
        DONE: begin
          h_ack <= 1'b0;
          e_ack <= 1'b0;
          h_err <= 1'b0;
          e_err <= 1'b0;
          block <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mon_tcam_arbiter.sv
// tb_mon_tcam_arbiter: transaction-timing model plus directed and random stimulus for the TCAM arbiter.
module tb_mon_tcam_arbiter;
  localparam int TW = 104;
  localparam int AW = 4;
  localparam int T = 8;
  logic axi_aclk = 1'b0, axi_resetn = 1'b0;
  logic h_req = 0, h_wr = 0, e_req = 0, e_wr = 0;
  logic [AW-1:0] h_addr = '0, e_addr = '0;
  logic [TW-1:0] h_rule = '0, h_mask = '0, e_rule = '0, e_mask = '0;
  logic h_ack, h_err, e_ack, e_err, mon_rd_req, mon_wr_req, busy;
  logic [TW-1:0] h_rd_rule, h_rd_mask, e_rd_rule, e_rd_mask, mon_wr_rule, mon_wr_rulemask;
  logic [AW-1:0] mon_rd_addr, mon_wr_addr;
  logic [TW-1:0] mon_rd_rule = '0, mon_rd_rulemask = '0;
  logic mon_rd_ack = 0, mon_wr_ack = 0;
  int tests = 0, fails = 0;
  mon_tcam_arbiter #(.TUPLE_WIDTH(TW), .MON_LUT_DEPTH_BITS(AW), .TIMEOUT_CYCLES(T)) dut (
    .axi_aclk(axi_aclk), .axi_resetn(axi_resetn),
    .h_req(h_req), .h_wr(h_wr), .h_addr(h_addr), .h_rule(h_rule), .h_mask(h_mask),
    .h_ack(h_ack), .h_err(h_err), .h_rd_rule(h_rd_rule), .h_rd_mask(h_rd_mask),
    .e_req(e_req), .e_wr(e_wr), .e_addr(e_addr), .e_rule(e_rule), .e_mask(e_mask),
    .e_ack(e_ack), .e_err(e_err), .e_rd_rule(e_rd_rule), .e_rd_mask(e_rd_mask),
    .mon_rd_req(mon_rd_req), .mon_wr_req(mon_wr_req), .mon_rd_addr(mon_rd_addr),
    .mon_wr_addr(mon_wr_addr), .mon_wr_rule(mon_wr_rule), .mon_wr_rulemask(mon_wr_rulemask),
    .mon_rd_rule(mon_rd_rule), .mon_rd_rulemask(mon_rd_rulemask),
    .mon_rd_ack(mon_rd_ack), .mon_wr_ack(mon_wr_ack), .busy(busy)
  );
  always #5 axi_aclk = ~axi_aclk;
  task automatic chk(input string n, input logic [TW-1:0] a, input logic [TW-1:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic logic [TW-1:0] rnd();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[TW-1:0];
  endfunction
  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask
  task automatic do_reset();
    axi_resetn = 1'b0;
    step();
    step();
    axi_resetn = 1'b1;
    repeat (4) step();
  endtask
  // Model: a transaction granted at the end of cycle g strobes in g+1, may complete on a
  // matching ack in cycles g+2..g+T+1, and acks one cycle after completing (or timing out).
  bit m_act, m_who, m_wr, m_err, m_last = 1'b1, hk, ek;
  int m_g, m_d = -1, m_blk = -1, rel = 0, cyc = 0;
  logic [AW-1:0] m_addr;
  logic [TW-1:0] m_rule, m_mask, m_hr, m_hm, m_er, m_em;
  bit strb, ackc;
  initial forever begin
    @(negedge axi_aclk);
    if (!axi_resetn) begin
      m_act = 0; m_last = 1; m_blk = -1; m_d = -1; rel = 0;
      m_hr = '0; m_hm = '0; m_er = '0; m_em = '0;
    end
    strb = m_act && cyc == m_g + 1;
    ackc = m_act && cyc == m_d;
    chk("busy", busy, m_act);
    chk("rd_strobe", mon_rd_req, strb && !m_wr);
    chk("wr_strobe", mon_wr_req, strb && m_wr);
    chk("h_ack", h_ack, ackc && !m_who);
    chk("e_ack", e_ack, ackc && m_who);
    chk("h_err", h_err, ackc && !m_who && m_err);
    chk("e_err", e_err, ackc && m_who && m_err);
    chk("h_rd_rule", h_rd_rule, m_hr);
    chk("h_rd_mask", h_rd_mask, m_hm);
    chk("e_rd_rule", e_rd_rule, m_er);
    chk("e_rd_mask", e_rd_mask, m_em);
    if (strb && m_wr) begin
      chk("wr_addr", mon_wr_addr, m_addr);
      chk("wr_rule", mon_wr_rule, m_rule);
      chk("wr_mask", mon_wr_rulemask, m_mask);
    end
    if (strb && !m_wr) chk("rd_addr", mon_rd_addr, m_addr);
    if (axi_resetn) begin
      if (!m_act) begin
        hk = h_req && !(m_blk == cyc && !m_last);
        ek = e_req && !(m_blk == cyc && m_last);
        if (rel >= 2 && (hk || ek)) begin
          m_who = (hk && ek) ? !m_last : ek;
          m_last = m_who;
          m_wr = m_who ? e_wr : h_wr;
          m_addr = m_who ? e_addr : h_addr;
          m_rule = m_who ? e_rule : h_rule;
          m_mask = m_who ? e_mask : h_mask;
          m_act = 1; m_g = cyc; m_d = -1;
        end
      end else if (m_d < 0 && cyc >= m_g + 2) begin
        if (m_wr ? mon_wr_ack : mon_rd_ack) begin
          m_d = cyc + 1; m_err = 0;
          if (!m_wr && m_who) begin m_er = mon_rd_rule; m_em = mon_rd_rulemask; end
          if (!m_wr && !m_who) begin m_hr = mon_rd_rule; m_hm = mon_rd_rulemask; end
        end else if (cyc == m_g + T + 1) begin
          m_d = cyc + 1; m_err = 1;
        end
      end else if (m_d == cyc) begin
        m_act = 0; m_blk = cyc + 1;
      end
      if (rel < 10) rel++;
    end
    cyc++;
  end
  // TCAM responder: mode 0 silent, 1 random acks/data, 2 scripted delays after each strobe
  int mode = 0, dly = 1, wdly = 0, pend = 0, wpend = 0;
  bit pw;
  logic [TW-1:0] rdv = '0;
  initial forever begin
    @(posedge axi_aclk);
    #1;
    mon_rd_ack = 0;
    mon_wr_ack = 0;
    if (mode == 1) begin
      mon_rd_ack = ($urandom % 6) == 0;
      mon_wr_ack = ($urandom % 6) == 0;
      mon_rd_rule = rnd();
      mon_rd_rulemask = rnd();
    end else if (mode == 2) begin
      mon_rd_rule = rdv;
      mon_rd_rulemask = ~rdv;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin if (pw) mon_wr_ack = 1; else mon_rd_ack = 1; end
      end
      if (wpend > 0) begin
        wpend--;
        if (wpend == 0) begin if (pw) mon_rd_ack = 1; else mon_wr_ack = 1; end
      end
      if (mon_wr_req || mon_rd_req) begin pend = dly; wpend = wdly; pw = mon_wr_req; end
    end
  end
  int n, pulses;
  bit seen;
  bit q[$];
  initial begin
    repeat (3) step();
    axi_resetn = 1'b1;
    repeat (4) step();
    // host read of addr 3, ack two cycles after the strobe
    mode = 2; dly = 2; rdv = 104'hABC;
    h_wr = 0; h_addr = 3; h_req = 1;
    step();
    chk("r40_strobe", mon_rd_req, 1);
    chk("r40_addr", mon_rd_addr, 3);
    h_req = 0;
    n = 0;
    while (!h_ack && n < 20) begin step(); n++; end
    chk("r40_latency", n, 3);
    chk("r40_rule", h_rd_rule, 104'hABC);
    chk("r40_err", h_err, 0);
    chk("r40_eack", e_ack, 0);
    repeat (3) step();
    // simultaneous requests after reset alternate starting with the host
    do_reset();
    dly = 1; h_req = 1; e_req = 1;
    q.delete();
    repeat (30) begin
      step();
      if (h_ack) q.push_back(1'b0);
      if (e_ack) q.push_back(1'b1);
    end
    h_req = 0; e_req = 0;
    chk("r41_count", q.size() >= 4, 1);
    for (int i = 0; i < 4; i++) chk("r41_order", q[i], i % 2);
    repeat (8) step();
    // engine write that is never acked times out
    mode = 0;
    e_wr = 1; e_addr = 5; e_rule = rnd(); e_mask = rnd(); e_req = 1;
    step();
    chk("r42_strobe", mon_wr_req, 1);
    chk("r42_addr", mon_wr_addr, 5);
    e_req = 0;
    n = 0; pulses = 0;
    while (!e_ack && n < 40) begin step(); n++; pulses += int'(mon_wr_req); end
    chk("r42_latency", n, 9);
    chk("r42_err", e_err, 1);
    chk("r42_extra_strobe", pulses, 0);
    chk("r42_hack", h_ack, 0);
    repeat (3) step();
    // host write: wrong-kind ack first, matching ack six cycles after the strobe
    mode = 2; dly = 6; wdly = 1;
    h_wr = 1; h_addr = 9; h_rule = rnd(); h_mask = rnd(); h_req = 1;
    step();
    h_req = 0;
    n = 0;
    while (!h_ack && n < 40) begin step(); n++; end
    chk("r43_latency", n, 7);
    chk("r43_err", h_err, 0);
    wdly = 0;
    repeat (3) step();
    // matching ack on the terminal timeout cycle wins
    dly = T; rdv = 104'h5A5; h_wr = 0; h_req = 1;
    step();
    h_req = 0;
    n = 0;
    while (!h_ack && n < 40) begin step(); n++; end
    chk("r30_latency", n, 9);
    chk("r30_err", h_err, 0);
    chk("r30_rule", h_rd_rule, 104'h5A5);
    repeat (3) step();
    // one cycle too late: timeout, read result unchanged
    dly = T + 1; rdv = 104'h777; h_req = 1;
    step();
    h_req = 0;
    n = 0;
    while (!h_ack && n < 40) begin step(); n++; end
    chk("r29_latency", n, 9);
    chk("r29_err", h_err, 1);
    chk("r29_rule_kept", h_rd_rule, 104'h5A5);
    repeat (4) step();
    // reset during WAIT_ACK, late ack after release is ignored
    dly = 4; h_wr = 0; h_req = 1;
    step();
    h_req = 0;
    step();
    step();
    axi_resetn = 0;
    step();
    axi_resetn = 1;
    seen = 0;
    repeat (6) begin step(); seen |= h_ack; end
    chk("r44_noack", seen, 0);
    chk("r44_busy", busy, 0);
    chk("r44_rule_cleared", h_rd_rule, 0);
    dly = 1; h_req = 1; e_req = 1;
    n = 0;
    while (!(h_ack || e_ack) && n < 20) begin step(); n++; end
    chk("r44_tie_host", h_ack, 1);
    h_req = 0; e_req = 0;
    repeat (8) step();
    // host holds req through its ack: one idle cycle of masking before the regrant
    h_wr = 0; h_req = 1;
    n = 0;
    while (!h_ack && n < 20) begin step(); n++; end
    step();
    chk("r45_masked", busy, 0);
    step();
    chk("r45_idle2", busy, 0);
    step();
    chk("r45_regrant", mon_rd_req, 1);
    h_req = 0;
    repeat (10) step();
    // random traffic, with a reset in the middle
    mode = 1;
    for (int i = 0; i < 3000; i++) begin
      h_req = ($urandom % 3) != 0;
      e_req = ($urandom % 3) != 0;
      h_wr = $urandom % 2; e_wr = $urandom % 2;
      h_addr = AW'($urandom); e_addr = AW'($urandom);
      h_rule = rnd(); h_mask = rnd(); e_rule = rnd(); e_mask = rnd();
      if (i == 1500) axi_resetn = 0;
      if (i == 1502) axi_resetn = 1;
      step();
    end
    mode = 0; h_req = 0; e_req = 0;
    repeat (20) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
